// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package seq_mult_pkg;

    // Controller states: latch operands in IDLE, iterate in RUN, publish result in FIN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int MULT_WIDTH_DEFAULT = 32;

    // Magnitude of a default-width operand. The most negative value maps to
    // 2^(W-1), which still fits an unsigned W-bit result.
    function automatic logic [MULT_WIDTH_DEFAULT-1:0] sign_mag(
        input logic [MULT_WIDTH_DEFAULT-1:0] value,
        input logic                          is_signed
    );
        return (is_signed && value[MULT_WIDTH_DEFAULT-1])
            ? (~value + MULT_WIDTH_DEFAULT'(1))
            : value;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the CPU control path and the multiplier.
//
// Handshake: the master raises start with operands valid; the request is taken
// on a rising edge only while the multiplier is idle, otherwise it is dropped
// (no queuing). done is a one-cycle pulse in the cycle hi/lo first show the new
// product; busy is low in that cycle, so a new start there is accepted.
interface seq_multiplier_if #(
    parameter int WIDTH = seq_mult_pkg::MULT_WIDTH_DEFAULT
) ();
    import seq_mult_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    state_t           dbg_state;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/seq_multiplier_twos_negate.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the final sign fix of the double-width product.
module twos_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_value
);
    assign o_value = i_neg ? (~i_value + W'(1)) : i_value;
endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (MULT/MULTU), one product bit per cycle.
// Operands are reduced to magnitudes, multiplied unsigned, and the 2*WIDTH
// product is negated at the end when the operand signs differ.
// Build option: define SEQ_MULT_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero; otherwise latency is fixed.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             reset,
    seq_multiplier_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mpl;
    logic [WIDTH:0]     r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_raw;
    logic [2*WIDTH-1:0] w_aligned;
    logic [2*WIDTH-1:0] w_product;
    logic               w_last;

    assign w_neg_a = bus.is_signed & bus.op_a[WIDTH-1];
    assign w_neg_b = bus.is_signed & bus.op_b[WIDTH-1];

    twos_negate #(.W(WIDTH)) u_mag_a (
        .i_neg   (w_neg_a),
        .i_value (bus.op_a),
        .o_value (w_mag_a)
    );

    twos_negate #(.W(WIDTH)) u_mag_b (
        .i_neg   (w_neg_b),
        .i_value (bus.op_b),
        .o_value (w_mag_b)
    );

    // The accumulator is one bit wider than the multiplicand so the carry of
    // the add survives into the shift.
    assign w_sum = r_mpl[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;

    // After the shift the accumulator MSB is always zero, so the product is
    // the low WIDTH accumulator bits on top of the multiplier register.
    assign w_raw = {r_acc[WIDTH-1:0], r_mpl};

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] w_shift;

    // Exit once the bits still to be consumed are all zero; further
    // iterations would only shift, so the product is realigned instead.
    assign w_last    = (r_cnt == LAST_ITER) || (r_rem[WIDTH-1:1] == '0);
    assign w_shift   = CNT_W'(WIDTH) - r_cnt;
    assign w_aligned = w_raw >> w_shift;

    // Track the unconsumed multiplier bits alongside the main datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_rem <= w_mag_b;
        end else if (r_state == RUN) begin
            r_rem <= r_rem >> 1;
        end
    end
`else
    assign w_last    = (r_cnt == LAST_ITER);
    assign w_aligned = w_raw;
`endif

    twos_negate #(.W(2 * WIDTH)) u_sign_fix (
        .i_neg   (r_neg),
        .i_value (w_aligned),
        .o_value (w_product)
    );

    // Controller and datapath: latch, iterate, then publish hi/lo in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_mpl   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand <= w_mag_a;
                        r_mpl   <= w_mag_b;
                        r_neg   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_busy  <= 1'b1;
                    r_acc   <= {1'b0, w_sum[WIDTH:1]};
                    r_mpl   <= {w_sum[0], r_mpl[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_hi    <= w_product[2*WIDTH-1:WIDTH];
                    r_lo    <= w_product[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=32: table of operand/product vectors,
// random signed/unsigned pairs against a behavioural product, and hand-written
// sequences for ignored start, back-to-back issue and reset mid-operation.
// Latency expectations follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;
    localparam int W       = 32;
    localparam int NVEC    = 19;
    localparam int BUDGET  = 200;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_applied = 0;
    int   n_miscmp = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;

    logic [2*W-1:0] exp_q[$];
    vec_t           vecs[NVEC];

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case a sequence wedges outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (sgn) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Cycles from the accepting edge to the done edge.
    function automatic int exp_latency(input logic sgn, input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        int           k;
        mag = (sgn && b[W-1]) ? (~b + 32'd1) : b;
        k = 1;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) k = i + 1;
        end
        return k + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] req);
        n_applied++;
        if (act !== req) begin
            n_miscmp++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Drive one request; it is accepted on the next rising edge.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] e);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Wait for done, then score latency, busy length and the product.
    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
        int             busy_n;
        bit             seen;
        logic [2*W-1:0] e;
        busy_n = bus.busy ? 1 : 0;
        seen   = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_n++;
        end
        if (!seen) begin
            n_applied++;
            n_miscmp++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, BUDGET);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        done_cyc = cyc;
        check({tag, " latency"}, 64'(cyc - start_cyc), 64'(exp_lat));
        if (exp_busy >= 0) check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        if (exp_q.size() == 0) begin
            n_applied++;
            n_miscmp++;
            $display("FAIL %s result: got %h, want nothing (queue empty)", tag, {bus.hi, bus.lo});
        end else begin
            e = exp_q.pop_front();
            check({tag, " result"}, {bus.hi, bus.lo}, e);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        int d1;
        int nd;
        logic [2*W-1:0] e;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        reset         = 1'b1;

        vecs[0]  = '{1'b0, 32'd3,         32'd5,         64'd15};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF,  32'h00000007,  64'hFFFFFFFF_FFFFFFF9};
        vecs[3]  = '{1'b1, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
        vecs[4]  = '{1'b0, 32'd9,         32'd1,         64'd9};
        vecs[5]  = '{1'b0, 32'd0,         32'h12345678,  64'd0};
        vecs[6]  = '{1'b1, 32'h80000000,  32'h00000001,  64'hFFFFFFFF_80000000};
        vecs[7]  = '{1'b1, 32'h7FFFFFFF,  32'h80000000,  64'hC0000000_80000000};
        vecs[8]  = '{1'b1, 32'hFFFFFFFE,  32'hFFFFFFFD,  64'd6};
        vecs[9]  = '{1'b0, 32'h80000000,  32'h00000002,  64'h00000001_00000000};
        vecs[10] = '{1'b1, 32'h00000000,  32'h80000000,  64'd0};
        for (int i = 11; i < NVEC; i++) begin
            vecs[i].sgn = 1'($urandom_range(0, 1));
            vecs[i].a   = $urandom;
            vecs[i].b   = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            vecs[i].exp = model(vecs[i].sgn, vecs[i].a, vecs[i].b);
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            int lat;
            lat = exp_latency(vecs[i].sgn, vecs[i].b);
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_result($sformatf("vec%0d", i), lat, lat - 1);
        end

        // start during a run is dropped; the first result is unaffected.
        issue(1'b0, 32'd3, 32'h80000005, 64'h00000001_8000000F);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_result("ignore", W + 1, -1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        count_dones(40, nd);
        check("ignore extra_done", 64'(nd), 64'd0);
        check("ignore busy_after", 64'(bus.busy), 64'd0);
        check("ignore result_held", {bus.hi, bus.lo}, 64'h00000001_8000000F);

        // start in the done cycle is accepted: one result per WIDTH+2 cycles.
        issue(1'b0, 32'hFFFF0000, 32'h80000001, 64'h7FFF8000_FFFF0000);
        wait_result("b2b_a", W + 1, W);
        d1 = done_cyc;
        issue(1'b0, 32'h00000002, 32'hC0000000, 64'h00000001_80000000);
        wait_result("b2b_b", W + 1, W);
        check("b2b spacing", 64'(done_cyc - d1), 64'(W + 2));

        // Reset 15 cycles into a run aborts it and clears the result.
        e = 64'hFFFFFFFE_00000001;
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        count_dones(40, nd);
        check("abort no_done", 64'(nd), 64'd0);
        check("abort hilo_held", {bus.hi, bus.lo}, 64'd0);

        // Normal operation resumes after the abort.
        issue(1'b1, 32'hFFFFFFFF, 32'h00000007, 64'hFFFFFFFF_FFFFFFF9);
        wait_result("post_abort", exp_latency(1'b1, 32'h00000007), exp_latency(1'b1, 32'h00000007) - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
